// File: rtl/ysyx_24090018_pkg.sv
// ysyx_24090018_pkg: shared IFU defaults and FIFO entry layout; IFU_ACCESS_FAULT_EN adds a per-entry fault bit.
package ysyx_24090018_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int INST_BYTES_DEF = 4;
`ifdef IFU_ACCESS_FAULT_EN
  localparam int FAULT_W = 1;
`else
  localparam int FAULT_W = 0;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ifu_entry_t;
endpackage

// File: rtl/ysyx_24090018_ifu_fifo.sv
// ysyx_24090018_ifu_fifo: registered sync FIFO with flush; head reads as zero while empty.
module ysyx_24090018_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && cnt_q != '0;
  assign valid_o = cnt_q != '0;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = flush_i ? '0 : push_i ? inc(wr_q) : wr_q;
    rd_d  = flush_i ? '0 : do_pop ? inc(rd_q) : rd_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i && !do_pop && !flush_i) assert (cnt_q != CW'(DEPTH));
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ysyx_24090018_ifu_pipe.sv
// ysyx_24090018_ifu_pipe: pipelined instruction fetch with credit-limited requests, redirect drop and fetch buffer.
// Build with IFU_ACCESS_FAULT_EN to carry bus errors to inst_fault and halt fetch until the next redirect.
module ysyx_24090018_ifu_pipe
  import ysyx_24090018_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int FIFO_DEPTH = 2,
  parameter int INST_BYTES = INST_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + FAULT_W;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
  logic [EW-1:0] push_data, head;
  logic credit, fire, push, halt;

  assign tgt    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign credit = ({1'b0, count} + {1'b0, outst_q}) < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_valid = rst_n & fetch_en & credit & !redirect_valid & !halt;
  assign imem_req_addr  = pc_q;
  assign fire = imem_req_valid & imem_req_ready;
  // Responses owed to a pre-redirect PC stream are counted off by drop_q.
  assign push = imem_resp_valid & (drop_q == '0) & !redirect_valid;

  always_comb begin
    pc_d      = redirect_valid ? tgt : fire ? pc_q + ADDR_WIDTH'(INST_BYTES) : pc_q;
    resp_pc_d = redirect_valid ? tgt : push ? resp_pc_q + ADDR_WIDTH'(INST_BYTES) : resp_pc_q;
    outst_d   = outst_q + CW'(fire) - CW'(imem_resp_valid);
    drop_d    = redirect_valid ? outst_q - CW'(imem_resp_valid) :
                (imem_resp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

`ifdef IFU_ACCESS_FAULT_EN
  logic halt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else halt_q <= redirect_valid ? 1'b0 : (push && imem_resp_err) ? 1'b1 : halt_q;
  end
  assign halt       = halt_q;
  assign push_data  = {resp_pc_q, imem_resp_data, imem_resp_err};
  assign inst_fault = head[0];
`else
  logic unused_err;
  assign unused_err = imem_resp_err;
  assign halt       = 1'b0;
  assign push_data  = {resp_pc_q, imem_resp_data};
  assign inst_fault = 1'b0;
`endif

  assign inst_pc = head[EW-1 -: ADDR_WIDTH];
  assign inst_o  = head[FAULT_W +: DATA_WIDTH];

  ysyx_24090018_ifu_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (inst_ready),
    .flush_i(redirect_valid),
    .data_i (push_data),
    .head_o (head),
    .count_o(count),
    .valid_o(inst_valid)
  );
endmodule

// File: doc/ysyx_24090018_ifu_pipe.md
Name: ysyx_24090018_ifu_pipe

Overview:
Parametrised instruction fetch unit: owns the PC, issues pipelined in-order requests on the instruction-memory bus, and buffers returned instructions in a small FIFO. Delivers {pc, inst} to IDU over valid/ready. Accepts redirects from EXU/WBU (branch, jump, trap) and discards any stale in-flight responses. Sits between the PC-select logic and IDU, replacing the single-cycle combinational fetch.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
DATA_WIDTH, 32, instruction/bus data width
RESET_PC, 32'h8000_0000, PC after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >=1; also caps outstanding requests
INST_BYTES, 4, PC increment per fetch

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  global fetch enable; 0 = no new requests
redirect_valid  in  1  redirect PC this cycle
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address (= pc register)
imem_resp_valid  in  1  response valid, in request order, always accepted
imem_resp_data  in  DATA_WIDTH  instruction word
imem_resp_err  in  1  bus access error for this response
inst_valid  out  1  FIFO head valid
inst_ready  in  1  IDU accepts head
inst_o  out  DATA_WIDTH  instruction
inst_pc  out  ADDR_WIDTH  address of inst_o
inst_fault  out  1  access fault flag (0 when feature off)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; imem_req_valid=0, inst_valid=0, inst_o=0, inst_pc=0, inst_fault=0. Reset mid-transaction abandons all in-flight responses; memory side is reset in the same domain.
- credit = (count + outstanding < FIFO_DEPTH).
- imem_req_valid = fetch_en & credit & !redirect_valid. Bus permits withdrawal of an unaccepted request; the only withdrawal causes are redirect and fetch_en falling.
- Request fire (valid&ready): pc += INST_BYTES (wraps modulo 2^ADDR_WIDTH), outstanding += 1.
- Response: outstanding -= 1. If drop_cnt>0: discarded, drop_cnt -= 1. Else pushed as {resp_pc, data, err}; resp_pc += INST_BYTES. Credit scheme guarantees no push to a full FIFO; push when full is an assertion failure.
- Minimum latency: response in cycle N -> inst_valid in cycle N+1 (registered FIFO, no bypass).
- Pop when inst_valid & inst_ready; simultaneous push and pop allowed at any count, including full.
- Redirect (takes priority over all else that cycle): pc and resp_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}; FIFO flushed (inst_valid=0 next cycle, same-cycle pop ignored); drop_cnt <= outstanding minus same-cycle response (a response arriving in the redirect cycle is discarded); no request issued that cycle. Back-to-back redirects: each reloads drop_cnt from current outstanding. Fetch resumes the cycle after redirect.
- fetch_en=0: outstanding responses still land in FIFO; no new requests.
- No state machine beyond counters; outstanding and drop_cnt width = clog2(FIFO_DEPTH)+1.

Optional Feature:
IFU_ACCESS_FAULT_EN. Defined: imem_resp_err stored per entry and driven on inst_fault; after pushing a faulting entry, imem_req_valid held 0 until the next redirect (trap handler redirects). Undefined: err ignored, inst_fault tied 0, no fetch halt; FIFO entry width excludes the flag.

Decomposition:
- Shared package ysyx_24090018_pkg: RESET_PC default, INST_BYTES, typedef ifu_entry_t {pc, inst, fault}.
- Sub-module ysyx_24090018_ifu_fifo: parametrised sync FIFO (width, depth, push, pop, flush, count, head). Instantiated once; counters, PC and drop logic stay in the top.

Test Plan:
- Reset release, ready=1, 1-cycle memory, inst_ready=1 -> requests 0x80000000, 0x80000004, 0x80000008; inst_pc follows with 2-cycle lag, no bubbles after fill.
- inst_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests fire, then imem_req_valid=0; raising inst_ready restarts fetch, no lost/duplicated PCs.
- 2 outstanding, redirect to 0x80001002 -> both stale responses dropped; next request 0x80001000; first delivered inst_pc=0x80001000.
- Redirect in same cycle as a response and an inst_ready pop -> response discarded, FIFO empty next cycle, drop_cnt = 1 if one other was in flight.
- pc=0xFFFFFFFC with ADDR_WIDTH=32 -> next request 0x00000000.
- IFU_ACCESS_FAULT_EN defined, resp_err=1 on 2nd fetch -> inst_fault=1 on that entry, no further requests until redirect; macro undefined -> inst_fault=0, fetch continues.
